// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: occupancy state encoding and its count decode.
package pipe_pkg;

  typedef enum logic [1:0] {eEMPTY, eONE, eFULL} pipe_state_e;

  function automatic logic [1:0] occ_of(input pipe_state_e s);
    logic [1:0] occ;
    case (s)
      eONE:    occ = 2'd1;
      eFULL:   occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_stage_skid.sv
// Generic valid/ready stage register, 1-cycle latency, optional skid entry.
// Back-pressure: with skid, ready_o decodes from state flops only; without, ready_o follows ready_i.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int width_p   = 64,
  parameter bit skid_en_p = 1'b1
) (
  input  logic               clk,
  input  logic               n_reset,
  input  logic               valid_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  input  logic               flush_i,
  output logic               valid_o,
  output logic [width_p-1:0] data_o,
  input  logic               ready_i,
  output logic [1:0]         occupancy_o
);

  pipe_state_e        r_state;
  pipe_state_e        w_state_nxt;
  logic [width_p-1:0] r_head;
  logic [width_p-1:0] w_skid_dat;
  logic               w_head_ld;
  logic               w_head_from_skid;
  logic               w_skid_ld;
  logic               w_acc;
  logic               w_emit;

  assign w_acc       = valid_i & ready_o;
  assign w_emit      = valid_o & ready_i;
  assign valid_o     = (r_state != eEMPTY);
  assign data_o      = r_head;
  assign occupancy_o = occ_of(r_state);

  always_comb begin
    w_state_nxt      = r_state;
    w_head_ld        = 1'b0;
    w_head_from_skid = 1'b0;
    w_skid_ld        = 1'b0;
    case (r_state)
      eEMPTY: begin
        if (w_acc) begin
          w_state_nxt = eONE;
          w_head_ld   = 1'b1;
        end
      end
      eONE: begin
        if (w_acc && w_emit) begin
          w_head_ld = 1'b1;
        end else if (w_acc) begin
          // Without the skid entry ready_o tracks ready_i here, so this branch is dead.
          if (skid_en_p) begin
            w_state_nxt = eFULL;
            w_skid_ld   = 1'b1;
          end
        end else if (w_emit) begin
          w_state_nxt = eEMPTY;
        end
      end
      eFULL: begin
        if (w_emit) begin
          w_state_nxt      = eONE;
          w_head_ld        = 1'b1;
          w_head_from_skid = 1'b1;
        end
      end
      default: w_state_nxt = eEMPTY;
    endcase
    // A same-cycle emit has already been consumed downstream; only held entries are dropped.
    if (flush_i) begin
      w_state_nxt = eEMPTY;
      w_head_ld   = 1'b0;
      w_skid_ld   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state <= eEMPTY;
      r_head  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_head_ld) begin
        r_head <= w_head_from_skid ? w_skid_dat : data_i;
      end
    end
  end

  if (skid_en_p) begin : g_skid
    logic [width_p-1:0] r_skid;

    always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
        r_skid <= '0;
      end else if (w_skid_ld) begin
        r_skid <= data_i;
      end
    end

    assign w_skid_dat = r_skid;
    assign ready_o    = (r_state != eFULL);
  end else begin : g_noskid
    logic w_skid_ld_unused;

    assign w_skid_ld_unused = w_skid_ld;
    assign w_skid_dat       = '0;
    assign ready_o          = (r_state == eEMPTY) | ready_i;
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed vector tables for both modes, async reset, random scoreboard run.
module tb_pipe_stage_skid;

  typedef struct {
    logic        vi;
    logic [31:0] di;
    logic        ri;
    logic        fl;
    logic        ev;
    logic [31:0] ed;
    logic        er;
    logic [1:0]  eo;
  } vec_t;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;

  logic        vi_s = 1'b0, ri_s = 1'b0, fl_s = 1'b0;
  logic [31:0] di_s = '0;
  logic        vo_s, ro_s;
  logic [31:0] do_s;
  logic [1:0]  occ_s;

  logic        vi_n = 1'b0, ri_n = 1'b0, fl_n = 1'b0;
  logic [31:0] di_n = '0;
  logic        vo_n, ro_n;
  logic [31:0] do_n;
  logic [1:0]  occ_n;

  int n_tests = 0;
  int n_fail  = 0;

  vec_t        tab_s[14];
  vec_t        tab_n[10];
  logic [31:0] q_s[$];
  logic [31:0] q_n[$];
  bit          stall_prev[2];
  logic [31:0] dprev[2];

  always #5 clk = ~clk;

  pipe_stage_skid #(.width_p(32), .skid_en_p(1'b1)) u_dut_s (
    .clk(clk), .n_reset(n_reset), .valid_i(vi_s), .data_i(di_s), .ready_o(ro_s),
    .flush_i(fl_s), .valid_o(vo_s), .data_o(do_s), .ready_i(ri_s), .occupancy_o(occ_s)
  );

  pipe_stage_skid #(.width_p(32), .skid_en_p(1'b0)) u_dut_n (
    .clk(clk), .n_reset(n_reset), .valid_i(vi_n), .data_i(di_n), .ready_o(ro_n),
    .flush_i(fl_n), .valid_o(vo_n), .data_o(do_n), .ready_i(ri_n), .occupancy_o(occ_n)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic vi, input logic [31:0] di, input logic ri, input logic fl,
                              input logic ev, input logic [31:0] ed, input logic er, input logic [1:0] eo);
    vec_t v;
    v.vi = vi; v.di = di; v.ri = ri; v.fl = fl;
    v.ev = ev; v.ed = ed; v.er = er; v.eo = eo;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input bit skid, input int idx);
    string p;
    p = $sformatf("%s[%0d]", skid ? "skid" : "noskid", idx);
    if (skid) begin
      vi_s = v.vi; di_s = v.di; ri_s = v.ri; fl_s = v.fl;
    end else begin
      vi_n = v.vi; di_n = v.di; ri_n = v.ri; fl_n = v.fl;
    end
    #1;
    chk({p, ".valid_o"},     skid ? 32'(vo_s)  : 32'(vo_n),  32'(v.ev));
    chk({p, ".data_o"},      skid ? do_s       : do_n,       v.ed);
    chk({p, ".ready_o"},     skid ? 32'(ro_s)  : 32'(ro_n),  32'(v.er));
    chk({p, ".occupancy_o"}, skid ? 32'(occ_s) : 32'(occ_n), 32'(v.eo));
    @(posedge clk);
    #1;
    vi_s = 1'b0; ri_s = 1'b0; fl_s = 1'b0;
    vi_n = 1'b0; ri_n = 1'b0; fl_n = 1'b0;
  endtask

  task automatic model_step(input bit skid);
    logic        vi, ri, fl, ov, ordy, exp_rdy, emit, acc;
    logic [31:0] di, od;
    logic [1:0]  occ;
    logic [31:0] q[$];
    int          m, sz;
    string       p;
    m = skid ? 1 : 0;
    p = skid ? "rnd_skid" : "rnd_noskid";
    if (skid) begin
      vi = vi_s; di = di_s; ri = ri_s; fl = fl_s; ov = vo_s; od = do_s; ordy = ro_s; occ = occ_s; q = q_s;
    end else begin
      vi = vi_n; di = di_n; ri = ri_n; fl = fl_n; ov = vo_n; od = do_n; ordy = ro_n; occ = occ_n; q = q_n;
    end
    sz      = q.size();
    exp_rdy = skid ? (sz < 2) : ((sz == 0) || ri);
    chk({p, ".occupancy_o"}, 32'(occ), 32'(sz));
    chk({p, ".valid_o"}, 32'(ov), 32'(sz != 0));
    chk({p, ".ready_o"}, 32'(ordy), 32'(exp_rdy));
    if (sz != 0) chk({p, ".data_o_order"}, od, q[0]);
    if (stall_prev[m]) begin
      chk({p, ".stall_valid"}, 32'(ov), 32'd1);
      chk({p, ".stall_data"}, od, dprev[m]);
    end
    emit = (sz != 0) && ri;
    acc  = vi && exp_rdy;
    if (emit) void'(q.pop_front());
    if (fl) q.delete();
    else if (acc) q.push_back(di);
    stall_prev[m] = (sz != 0) && !ri && !fl;
    dprev[m]      = od;
    if (skid) q_s = q; else q_n = q;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    tab_s[0]  = mk(1, 32'h11, 1, 0, 0, 32'h00, 1, 2'd0);
    tab_s[1]  = mk(1, 32'h22, 1, 0, 1, 32'h11, 1, 2'd1);
    tab_s[2]  = mk(1, 32'h33, 1, 0, 1, 32'h22, 1, 2'd1);
    tab_s[3]  = mk(0, 32'h00, 1, 0, 1, 32'h33, 1, 2'd1);
    tab_s[4]  = mk(1, 32'h0A, 1, 0, 0, 32'h33, 1, 2'd0);
    tab_s[5]  = mk(1, 32'h0B, 0, 0, 1, 32'h0A, 1, 2'd1);
    tab_s[6]  = mk(1, 32'h77, 0, 0, 1, 32'h0A, 0, 2'd2);
    tab_s[7]  = mk(0, 32'h00, 1, 0, 1, 32'h0A, 0, 2'd2);
    tab_s[8]  = mk(0, 32'h00, 1, 0, 1, 32'h0B, 1, 2'd1);
    tab_s[9]  = mk(0, 32'h00, 0, 0, 0, 32'h0B, 1, 2'd0);
    tab_s[10] = mk(1, 32'h0A, 0, 0, 0, 32'h0B, 1, 2'd0);
    tab_s[11] = mk(1, 32'h0B, 0, 0, 1, 32'h0A, 1, 2'd1);
    tab_s[12] = mk(1, 32'h0C, 1, 1, 1, 32'h0A, 0, 2'd2);
    tab_s[13] = mk(0, 32'h00, 1, 0, 0, 32'h0A, 1, 2'd0);

    tab_n[0]  = mk(1, 32'h05, 0, 0, 0, 32'h00, 1, 2'd0);
    tab_n[1]  = mk(1, 32'h06, 0, 0, 1, 32'h05, 0, 2'd1);
    tab_n[2]  = mk(1, 32'h06, 1, 0, 1, 32'h05, 1, 2'd1);
    tab_n[3]  = mk(1, 32'h07, 0, 0, 1, 32'h06, 0, 2'd1);
    tab_n[4]  = mk(1, 32'h07, 1, 0, 1, 32'h06, 1, 2'd1);
    tab_n[5]  = mk(0, 32'h00, 0, 0, 1, 32'h07, 0, 2'd1);
    tab_n[6]  = mk(0, 32'h00, 1, 0, 1, 32'h07, 1, 2'd1);
    tab_n[7]  = mk(0, 32'h00, 0, 0, 0, 32'h07, 1, 2'd0);
    tab_n[8]  = mk(1, 32'h08, 1, 1, 0, 32'h07, 1, 2'd0);
    tab_n[9]  = mk(0, 32'h00, 0, 0, 0, 32'h07, 1, 2'd0);

    #2;
    chk("reset_skid.valid_o", 32'(vo_s), 32'd0);
    chk("reset_skid.data_o", do_s, 32'd0);
    chk("reset_skid.ready_o", 32'(ro_s), 32'd1);
    chk("reset_skid.occupancy_o", 32'(occ_s), 32'd0);
    chk("reset_noskid.valid_o", 32'(vo_n), 32'd0);
    chk("reset_noskid.ready_o", 32'(ro_n), 32'd1);
    chk("reset_noskid.occupancy_o", 32'(occ_n), 32'd0);
    @(posedge clk);
    #1;
    n_reset = 1'b1;

    for (int i = 0; i < 14; i++) run_vec(tab_s[i], 1'b1, i);
    for (int i = 0; i < 10; i++) run_vec(tab_n[i], 1'b0, i);

    // Fill the skid stage, then pulse reset between edges.
    vi_s = 1'b1; di_s = 32'h1A; ri_s = 1'b0;
    @(posedge clk); #1;
    di_s = 32'h1B;
    @(posedge clk); #1;
    vi_s = 1'b0;
    #1;
    chk("areset_pre.occupancy_o", 32'(occ_s), 32'd2);
    chk("areset_pre.data_o", do_s, 32'h1A);
    #1;
    n_reset = 1'b0;
    #1;
    chk("areset.valid_o", 32'(vo_s), 32'd0);
    chk("areset.data_o", do_s, 32'd0);
    chk("areset.occupancy_o", 32'(occ_s), 32'd0);
    chk("areset.ready_o", 32'(ro_s), 32'd1);
    chk("areset_noskid.data_o", do_n, 32'd0);
    #1;
    n_reset = 1'b1;
    @(posedge clk); #1;
    chk("areset_post.occupancy_o", 32'(occ_s), 32'd0);

    q_s.delete();
    q_n.delete();
    stall_prev[0] = 1'b0;
    stall_prev[1] = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      vi_s = ($urandom_range(0, 9) < 7);
      ri_s = ($urandom_range(0, 9) < 6);
      fl_s = ($urandom_range(0, 15) == 0);
      di_s = {16'(c), 16'($urandom)};
      vi_n = ($urandom_range(0, 9) < 7);
      ri_n = ($urandom_range(0, 9) < 5);
      fl_n = ($urandom_range(0, 15) == 0);
      di_n = {16'(c), 16'($urandom)};
      #1;
      model_step(1'b1);
      model_step(1'b0);
      @(posedge clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
